// File: rtl/cluster_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cluster_pkg : shared defaults, FSM state encoding and point type     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package cluster_pkg;

  localparam int CLUSTER_N = 16;
  localparam int CLUSTER_K = 2;
  localparam int CLUSTER_Q = 32;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_PAD   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic [CLUSTER_Q-1:0] x;
    logic [CLUSTER_Q-1:0] y;
  } point_t;

endpackage
`default_nettype wire

// File: rtl/cluster_stream_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cluster_stream_frontend : frames streamed points for a cluster       |
// | engine, runs it under a watchdog and drains its centroids.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cluster_stream_frontend
  import cluster_pkg::*;
#(
  parameter int N       = CLUSTER_N,
  parameter int K       = CLUSTER_K,
  parameter int Q       = CLUSTER_Q,
  parameter int TIMEOUT = 4096,
  localparam int IW     = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Q-1:0]  in_x,
  input  logic [Q-1:0]  in_y,
  input  logic          in_last,
  output logic [Q-1:0]  x [N],
  output logic [Q-1:0]  y [N],
  output logic          start,
  input  logic          done,
  input  logic [Q-1:0]  centroid_x [K],
  input  logic [Q-1:0]  centroid_y [K],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [Q-1:0]  out_x,
  output logic [Q-1:0]  out_y,
  output logic          short_frame,
  output logic          timeout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] i_q;
  logic [WW-1:0] wd_q;
  logic [Q-1:0]  x_q [N];
  logic [Q-1:0]  y_q [N];
  logic [Q-1:0]  cap_x_q [K];
  logic [Q-1:0]  cap_y_q [K];
  logic          short_q;
  logic          timeout_q;

  logic cnt_last, i_last, wd_expired;
  assign cnt_last   = (cnt_q == CW'(N - 1));
  assign i_last     = (i_q == IW'(K - 1));
  assign wd_expired = (wd_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt_last)     state_d = ST_START;
          else if (in_last) state_d = ST_PAD;
        end
      end
      ST_PAD:   if (cnt_last) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done)            state_d = ST_DRAIN;
        else if (wd_expired) state_d = ST_LOAD;
      end
      ST_DRAIN: if (out_ready && i_last) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // Handshake outputs are forced low while reset is held, before the first edge.
  always_comb begin
    in_ready  = 1'b0;
    start     = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_LOAD:  in_ready  = 1'b1;
        ST_START: start     = 1'b1;
        ST_DRAIN: out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      i_q       <= '0;
      wd_q      <= '0;
      short_q   <= 1'b0;
      timeout_q <= 1'b0;
      for (int n = 0; n < N; n++) begin
        x_q[n] <= '0;
        y_q[n] <= '0;
      end
      for (int k = 0; k < K; k++) begin
        cap_x_q[k] <= '0;
        cap_y_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            x_q[cnt_q] <= in_x;
            y_q[cnt_q] <= in_y;
            cnt_q      <= cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
              short_q   <= 1'b0;
              timeout_q <= 1'b0;
            end
            // An early last on the very first point must still flag the frame.
            if (in_last && !cnt_last) short_q <= 1'b1;
          end
        end
        ST_PAD: begin
          x_q[cnt_q] <= '0;
          y_q[cnt_q] <= '0;
          cnt_q      <= cnt_last ? '0 : cnt_q + 1'b1;
        end
        ST_WAIT: begin
          if (done) begin
            wd_q <= '0;
            for (int k = 0; k < K; k++) begin
              cap_x_q[k] <= centroid_x[k];
              cap_y_q[k] <= centroid_y[k];
            end
          end else if (wd_expired) begin
            wd_q      <= '0;
            timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) i_q <= i_last ? '0 : i_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign out_idx     = rst ? '0 : i_q;
  assign out_x       = rst ? '0 : cap_x_q[i_q];
  assign out_y       = rst ? '0 : cap_y_q[i_q];
  assign short_frame = short_q & ~rst;
  assign timeout     = timeout_q & ~rst;

endmodule
`default_nettype wire
